// File: rtl/tdc_sweep_controller.sv
// Sweeps a pulse1->pulse2 delay over [n_start, n_end], fires reps pulse pairs per delay and
// streams one TDC record (or a timeout record) per pair through a valid/ready handshake.
module tdc_sweep_controller #(
   parameter int TIMEOUT = 255,
   parameter int GAP     = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic [7:0]  n_start,
   input  logic [7:0]  n_end,
   input  logic [7:0]  n_step,
   input  logic [15:0] reps,
   input  logic        tdc_valid,
   input  logic [31:0] tdc_data,
   output logic        pulse1,
   output logic        pulse2,
   output logic        rec_valid,
   input  logic        rec_ready,
   output logic [7:0]  rec_delay,
   output logic [15:0] rec_rep,
   output logic [31:0] rec_data,
   output logic        rec_timeout,
   output logic        busy,
   output logic        done
);
   // One shared counter serves the delay wait, the result timeout and the inter-pair gap.
   localparam int CMAX = (TIMEOUT > GAP) ? ((TIMEOUT > 255) ? TIMEOUT : 255)
                                         : ((GAP > 255) ? GAP : 255);
   localparam int CW = $clog2(CMAX + 2);
   localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
   localparam logic [CW-1:0] GAP_C     = CW'(GAP);
   localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FIRE     = 3'd1,
      S_WAIT_N   = 3'd2,
      S_WAIT_RES = 3'd3,
      S_EMIT     = 3'd4,
      S_GAP_W    = 3'd5
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [7:0]     delay_q, delay_d, end_q, end_d, step_q, step_d;
   logic [15:0]    rep_q, rep_d, reps_q, reps_d;
   logic           pulse1_q, pulse1_d, pulse2_q, pulse2_d;
   logic           rec_valid_q, rec_valid_d, rec_timeout_q, rec_timeout_d;
   logic [7:0]     rec_delay_q, rec_delay_d;
   logic [15:0]    rec_rep_q, rec_rep_d;
   logic [31:0]    rec_data_q, rec_data_d;
   logic           busy_q, busy_d, done_q, done_d;

   logic [8:0]     delay_sum_s;
   logic [16:0]    rep_inc_s;
   logic           rep_more_s, sweep_end_s;
   logic [7:0]     next_delay_s;
   logic [CW-1:0]  delay_ext_s;

   // The 9-bit sum keeps a step past 255 from wrapping back into range.
   assign delay_sum_s  = {1'b0, delay_q} + {1'b0, step_q};
   assign rep_inc_s    = {1'b0, rep_q} + 17'd1;
   assign rep_more_s   = (rep_inc_s < {1'b0, reps_q});
   assign sweep_end_s  = !rep_more_s && (delay_sum_s > {1'b0, end_q});
   assign next_delay_s = rep_more_s ? delay_q : delay_sum_s[7:0];
   assign delay_ext_s  = CW'(delay_q);

   // Next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      delay_d       = delay_q;
      end_d         = end_q;
      step_d        = step_q;
      rep_d         = rep_q;
      reps_d        = reps_q;
      pulse1_d      = 1'b0;
      pulse2_d      = 1'b0;
      rec_valid_d   = rec_valid_q;
      rec_delay_d   = rec_delay_q;
      rec_rep_d     = rec_rep_q;
      rec_data_d    = rec_data_q;
      rec_timeout_d = rec_timeout_q;
      done_d        = 1'b0;
      if (abort && (state_q != S_IDLE)) begin
         state_d       = S_IDLE;
         cnt_d         = CNT_ZERO;
         delay_d       = 8'd0;
         rep_d         = 16'd0;
         rec_valid_d   = 1'b0;
         rec_delay_d   = 8'd0;
         rec_rep_d     = 16'd0;
         rec_data_d    = 32'd0;
         rec_timeout_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (n_start > n_end) begin
                     done_d = 1'b1;
                  end else begin
                     state_d  = S_FIRE;
                     delay_d  = n_start;
                     rep_d    = 16'd0;
                     end_d    = n_end;
                     step_d   = (n_step == 8'd0) ? 8'd1 : n_step;
                     reps_d   = (reps == 16'd0) ? 16'd1 : reps;
                     pulse1_d = 1'b1;
                     pulse2_d = (n_start == 8'd0);
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_FIRE: begin
               cnt_d = CNT_ONE;
               if (delay_q == 8'd0) begin
                  state_d = S_WAIT_RES;
               end else begin
                  state_d  = S_WAIT_N;
                  pulse2_d = (delay_q == 8'd1);
               end
            end
            // cnt_q is the number of cycles elapsed since pulse1.
            S_WAIT_N: begin
               if (pulse2_q) begin
                  state_d = S_WAIT_RES;
                  cnt_d   = CNT_ONE;
               end else begin
                  cnt_d    = cnt_q + CNT_ONE;
                  pulse2_d = ((cnt_q + CNT_ONE) == delay_ext_s);
               end
            end
            S_WAIT_RES: begin
               if (tdc_valid) begin
                  state_d       = S_EMIT;
                  rec_valid_d   = 1'b1;
                  rec_delay_d   = delay_q;
                  rec_rep_d     = rep_q;
                  rec_data_d    = tdc_data;
                  rec_timeout_d = 1'b0;
               end else if (cnt_q >= TIMEOUT_C) begin
                  state_d       = S_EMIT;
                  rec_valid_d   = 1'b1;
                  rec_delay_d   = delay_q;
                  rec_rep_d     = rep_q;
                  rec_data_d    = 32'd0;
                  rec_timeout_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            S_EMIT: begin
               if (rec_ready) begin
                  rec_valid_d = 1'b0;
                  if (sweep_end_s) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                     delay_d = 8'd0;
                     rep_d   = 16'd0;
                  end else begin
                     delay_d = next_delay_s;
                     rep_d   = rep_more_s ? rep_inc_s[15:0] : 16'd0;
                     if (GAP_C == CNT_ZERO) begin
                        state_d  = S_FIRE;
                        pulse1_d = 1'b1;
                        pulse2_d = (next_delay_s == 8'd0);
                     end else begin
                        state_d = S_GAP_W;
                        cnt_d   = CNT_ONE;
                     end
                  end
               end else begin
                  state_d = S_EMIT;
               end
            end
            S_GAP_W: begin
               if (cnt_q >= GAP_C) begin
                  state_d  = S_FIRE;
                  pulse1_d = 1'b1;
                  pulse2_d = (delay_q == 8'd0);
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= CNT_ZERO;
         delay_q       <= 8'd0;
         end_q         <= 8'd0;
         step_q        <= 8'd0;
         rep_q         <= 16'd0;
         reps_q        <= 16'd0;
         pulse1_q      <= 1'b0;
         pulse2_q      <= 1'b0;
         rec_valid_q   <= 1'b0;
         rec_delay_q   <= 8'd0;
         rec_rep_q     <= 16'd0;
         rec_data_q    <= 32'd0;
         rec_timeout_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         delay_q       <= delay_d;
         end_q         <= end_d;
         step_q        <= step_d;
         rep_q         <= rep_d;
         reps_q        <= reps_d;
         pulse1_q      <= pulse1_d;
         pulse2_q      <= pulse2_d;
         rec_valid_q   <= rec_valid_d;
         rec_delay_q   <= rec_delay_d;
         rec_rep_q     <= rec_rep_d;
         rec_data_q    <= rec_data_d;
         rec_timeout_q <= rec_timeout_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign pulse1      = pulse1_q;
   assign pulse2      = pulse2_q;
   assign rec_valid   = rec_valid_q;
   assign rec_delay   = rec_delay_q;
   assign rec_rep     = rec_rep_q;
   assign rec_data    = rec_data_q;
   assign rec_timeout = rec_timeout_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_tdc_sweep_controller.sv
// Bench for tdc_sweep_controller: directed table of sweeps, abort/reset corner sequences and
// random sweeps, all checked against a list-of-records model built from the sweep rules.
module tb_tdc_sweep_controller;
   localparam int TIMEOUT = 255;
   localparam int GAP     = 16;

   logic        clk = 1'b0;
   logic        reset, start, abort, tdc_valid, rec_ready;
   logic [7:0]  n_start, n_end, n_step;
   logic [15:0] reps;
   logic [31:0] tdc_data;
   logic        pulse1, pulse2, rec_valid, rec_timeout, busy, done;
   logic [7:0]  rec_delay;
   logic [15:0] rec_rep;
   logic [31:0] rec_data;

   always #5 clk = ~clk;

   tdc_sweep_controller #(.TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .n_start(n_start), .n_end(n_end), .n_step(n_step), .reps(reps),
      .tdc_valid(tdc_valid), .tdc_data(tdc_data),
      .pulse1(pulse1), .pulse2(pulse2),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_delay(rec_delay),
      .rec_rep(rec_rep), .rec_data(rec_data), .rec_timeout(rec_timeout),
      .busy(busy), .done(done)
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   typedef struct { int d; int r; } rec_t;
   rec_t exp_q[$];

   // Expected record list: every delay from n_start up to n_end (never past 255), reps each.
   function automatic void build_model(input int ns, input int ne, input int st, input int rp);
      int s;
      int n;
      s = (st == 0) ? 1 : st;
      n = (rp == 0) ? 1 : rp;
      exp_q.delete();
      if (ns <= ne) begin
         for (int d = ns; d <= ne && d <= 255; d += s)
            for (int r = 0; r < n; r++) exp_q.push_back('{d, r});
      end
   endfunction

   // Latency 0 means the TDC never answers.
   function automatic int pick_lat(input int fixed);
      int r;
      if (fixed >= 0) return fixed;
      r = $urandom_range(0, 19);
      if (r == 0) return 0;
      if (r == 1) return 255;
      return $urandom_range(1, 30);
   endfunction

   task automatic run_sweep(input int ns, input int ne, input int st, input int rp,
                            input int lat_f, input int stall_f,
                            output int nrec, output int last_d);
      int off, lat, exp_lat, L, stall, bad, extra;
      logic [31:0] dat, exp_dat;
      logic exp_to;
      build_model(ns, ne, st, rp);
      nrec = 0;
      last_d = -1;
      n_start = 8'(ns); n_end = 8'(ne); n_step = 8'(st); reps = 16'(rp);
      start = 1'b1;
      step();
      start = 1'b0;
      n_start = 8'($urandom); n_end = 8'($urandom); n_step = 8'($urandom); reps = 16'($urandom);
      if (exp_q.size() == 0) begin
         chk("empty_done", int'(done), 1);
         chk("empty_busy", int'(busy), 0);
         bad = 0;
         for (int k = 0; k < 20; k++) begin
            step();
            if (pulse1 || pulse2 || done || busy) bad++;
         end
         chk("empty_quiet", bad, 0);
         return;
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i == 0) begin
            chk("fire_after_start", int'(pulse1), 1);
            chk("busy_after_start", int'(busy), 1);
         end
         off = -1;
         extra = 0;
         for (int k = 0; k <= 300; k++) begin
            if (k > 0 && pulse1) extra++;
            if (pulse2) begin
               off = k;
               break;
            end
            step();
         end
         chk("p2_offset", off, exp_q[i].d);
         chk("p1_single", extra, 0);
         if (off < 0) return;
         L = pick_lat(lat_f);
         dat = $urandom;
         exp_lat = (L >= 1 && L <= TIMEOUT) ? L + 1 : TIMEOUT + 1;
         exp_dat = (L >= 1) ? dat : 32'd0;
         exp_to  = (L == 0);
         tdc_valid = 1'($urandom_range(0, 1));
         tdc_data  = ~dat;
         lat = -1;
         bad = 0;
         for (int j = 1; j <= TIMEOUT + 40; j++) begin
            step();
            if (rec_valid) begin
               lat = j;
               break;
            end
            if (pulse1 || pulse2) bad++;
            tdc_valid = (j == L);
            tdc_data  = (j == L) ? dat : $urandom;
            start     = 1'($urandom_range(0, 1));
            n_start   = 8'($urandom);
            reps      = 16'($urandom);
         end
         tdc_valid = 1'b0;
         start = 1'b0;
         chk("rec_latency", lat, exp_lat);
         chk("no_pulse_in_wait", bad, 0);
         if (lat < 0) return;
         stall = (stall_f >= 0) ? stall_f : $urandom_range(0, 4);
         bad = 0;
         for (int s = 0; s < stall; s++) begin
            rec_ready = 1'b0;
            tdc_valid = 1'($urandom_range(0, 1));
            tdc_data  = $urandom;
            if (!rec_valid || pulse1 || rec_delay != 8'(exp_q[i].d) || rec_rep != 16'(exp_q[i].r)
                || rec_data != exp_dat || rec_timeout != exp_to) bad++;
            step();
         end
         tdc_valid = 1'b0;
         rec_ready = 1'b1;
         chk("stall_stable", bad, 0);
         chk("rec_valid", int'(rec_valid), 1);
         chk("rec_delay", int'(rec_delay), exp_q[i].d);
         chk("rec_rep", int'(rec_rep), exp_q[i].r);
         chk("rec_data", int'(rec_data), int'(exp_dat));
         chk("rec_timeout", int'(rec_timeout), int'(exp_to));
         step();
         rec_ready = 1'b0;
         nrec++;
         last_d = exp_q[i].d;
         chk("rec_valid_drop", int'(rec_valid), 0);
         if (i == exp_q.size() - 1) begin
            chk("done_pulse", int'(done), 1);
            chk("busy_end", int'(busy), 0);
            step();
            chk("done_single", int'(done), 0);
         end else begin
            chk("busy_gap", int'(busy), 1);
            off = -1;
            for (int k = 1; k <= GAP + 20; k++) begin
               if (pulse1) begin
                  off = k;
                  break;
               end
               step();
            end
            chk("gap_len", off, GAP + 1);
            if (off < 0) return;
         end
      end
   endtask

   typedef struct { int ns; int ne; int st; int rp; int lat; int stall; int exp_n; int exp_last; } vec_t;
   vec_t tbl[$];
   int nrec, last_d, quiet, seen;

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; tdc_valid = 1'b0; rec_ready = 1'b0;
      n_start = 8'd0; n_end = 8'd0; n_step = 8'd0; reps = 16'd0; tdc_data = 32'd0;
      tbl.push_back('{3, 5, 1, 2, 4, 0, 6, 5});
      tbl.push_back('{0, 0, 1, 1, 3, 0, 1, 0});
      tbl.push_back('{0, 0, 1, 1, 0, 0, 1, 0});
      tbl.push_back('{1, 1, 1, 1, 255, 0, 1, 1});
      tbl.push_back('{250, 255, 10, 1, 2, 0, 1, 250});
      tbl.push_back('{9, 2, 1, 1, 4, 0, 0, -1});
      tbl.push_back('{5, 9, 0, 0, 2, 1, 5, 9});
      tbl.push_back('{10, 20, 4, 3, -1, -1, 9, 18});
      tbl.push_back('{254, 255, 1, 1, 5, 0, 2, 255});
      tbl.push_back('{0, 255, 128, 1, 1, 0, 2, 128});
      tbl.push_back('{7, 7, 1, 1, 6, 20, 1, 7});

      repeat (2) step();
      chk("reset_ctrl", int'({pulse1, pulse2, rec_valid, rec_timeout, busy, done}), 0);
      chk("reset_payload", int'(rec_delay) | int'(rec_rep) | int'(rec_data), 0);
      reset = 1'b0;
      step();

      foreach (tbl[i]) begin
         run_sweep(tbl[i].ns, tbl[i].ne, tbl[i].st, tbl[i].rp, tbl[i].lat, tbl[i].stall, nrec, last_d);
         chk("tbl_nrec", nrec, tbl[i].exp_n);
         chk("tbl_last_delay", last_d, tbl[i].exp_last);
         repeat (3) step();
      end

      // Abort while waiting for pulse2.
      n_start = 8'd20; n_end = 8'd30; n_step = 8'd1; reps = 16'd1;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("abort_pre_fire", int'(pulse1), 1);
      repeat (5) step();
      chk("abort_pre_busy", int'(busy), 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_ctrl", int'({pulse1, pulse2, rec_valid, rec_timeout, busy, done}), 0);
      chk("abort_payload", int'(rec_delay) | int'(rec_rep) | int'(rec_data), 0);
      quiet = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (pulse1 || pulse2 || busy || done || rec_valid) quiet++;
      end
      chk("abort_quiet", quiet, 0);
      run_sweep(3, 5, 1, 2, 4, 0, nrec, last_d);
      chk("abort_resweep_n", nrec, 6);

      // Reset while a record is pending.
      n_start = 8'd2; n_end = 8'd4; n_step = 8'd1; reps = 16'd1;
      tdc_valid = 1'b1; tdc_data = 32'hDEAD_BEEF; rec_ready = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      seen = 0;
      for (int k = 0; k < 60; k++) begin
         if (rec_valid) begin
            seen = 1;
            break;
         end
         step();
      end
      tdc_valid = 1'b0;
      chk("rst_emit_reached", seen, 1);
      chk("rst_emit_data", int'(rec_data), int'(32'hDEAD_BEEF));
      repeat (3) step();
      reset = 1'b1;
      #1;
      chk("rst_async_ctrl", int'({pulse1, pulse2, rec_valid, rec_timeout, busy, done}), 0);
      chk("rst_async_payload", int'(rec_delay) | int'(rec_rep) | int'(rec_data), 0);
      step();
      step();
      reset = 1'b0;
      quiet = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (pulse1 || pulse2 || busy || done || rec_valid) quiet++;
      end
      chk("rst_quiet", quiet, 0);
      run_sweep(0, 1, 1, 2, 3, 1, nrec, last_d);
      chk("rst_resweep_n", nrec, 4);

      // Random sweeps against the model.
      for (int t = 0; t < 5; t++) begin
         int ns, ne, st, rp;
         ns = $urandom_range(0, 40);
         if (ns > 0 && $urandom_range(0, 5) == 0) ne = $urandom_range(0, ns - 1);
         else ne = ns + $urandom_range(0, 15);
         st = $urandom_range(0, 6);
         rp = $urandom_range(0, 3);
         run_sweep(ns, ne, st, rp, -1, -1, nrec, last_d);
         chk("rand_nrec", nrec, exp_q.size());
         repeat (2) step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
